mult_share_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 17 +
 rtl/mult_share_arbiter_multiplier.sv | 15 +
 rtl/mult_share_arbiter.sv | 94 +++++++++
 tb/tb_mult_share_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-port multiplier arbiter: FSM states,
// default operand width and requester port indices.
package mult_arb_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Port indices double as the one-bit "who is being served" encoding.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_multiplier.sv
// Shared combinational unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
module multiplier
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Zero-extend both operands so the full product is kept, never truncated.
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// One operation in flight: IDLE (arbitrate/capture) -> CALC -> RESP (done).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t               state, next_state;
  logic                 last_served;
  logic                 win;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [2*WIDTH-1:0]   mult_p;

  multiplier #(.WIDTH(WIDTH)) u_multiplier (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, round-robin winner and operand select.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    win        = ~last_served;
    case (req)
      2'b01:   win = PORT0;
      2'b10:   win = PORT1;
      default: win = ~last_served;   // contention: the port not served last wins
    endcase
    sel_a = (win == PORT1) ? a1 : a0;
    sel_b = (win == PORT1) ? b1 : b0;
    case (state)
      IDLE:    if (|req) next_state = CALC;
      CALC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, grant, product register and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      gnt         <= 2'b00;
      product     <= '0;
      last_served <= PORT1;    // so port 0 wins the first contention
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op_a <= sel_a;
            op_b <= sel_b;
            gnt  <= (win == PORT1) ? 2'b10 : 2'b01;
          end
        end
        CALC: product <= mult_p;
        RESP: begin
          gnt         <= 2'b00;
          last_served <= gnt[1];   // gnt is one-hot here, bit 1 names the port
        end
        default: ;
      endcase
    end
  end

  // done mirrors the one-hot grant only during the response cycle.
  assign done = (state == RESP) ? gnt : 2'b00;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req;
  logic [W-1:0]   a0, b0, a1, b1;
  logic [1:0]     gnt, done;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model: an operation takes three cycles from the capture
  // decision; m_age counts how far along the current one is (0 = none).
  int   m_age;
  int   m_owner;
  int   m_last;
  int   m_pending;
  int   m_prod;

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .gnt     (gnt),
    .done    (done),
    .product (product),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] port_bit(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] exp_gnt();
    return (m_age != 0) ? port_bit(m_owner) : 2'b00;
  endfunction

  function automatic logic [1:0] exp_done();
    return (m_age == 2) ? port_bit(m_owner) : 2'b00;
  endfunction

  function automatic logic exp_busy();
    return (m_age != 0);
  endfunction

  function automatic logic [2*W-1:0] exp_prod();
    return (2*W)'(m_prod);
  endfunction

  task automatic model_reset();
    m_age     = 0;
    m_owner   = 0;
    m_last    = 1;
    m_pending = 0;
    m_prod    = 0;
  endtask

  // One clock: sample inputs, take the edge, advance the model, settle.
  task automatic cycle();
    logic [1:0]   rs;
    logic [W-1:0] sa0, sb0, sa1, sb1;
    rs = req; sa0 = a0; sb0 = b0; sa1 = a1; sb1 = b1;
    @(posedge clk);
    if (m_age == 0) begin
      if (rs != 2'b00) begin
        if (rs == 2'b11) m_owner = 1 - m_last;
        else             m_owner = rs[1] ? 1 : 0;
        m_pending = (m_owner == 1) ? int'(sa1) * int'(sb1) : int'(sa0) * int'(sb0);
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_prod = m_pending;
      m_age  = 2;
    end else begin
      m_last = m_owner;
      m_age  = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, done, busy, product} !== '0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b done=%b busy=%b product=%h, expected all 0", gnt, done, busy, product);
    end
    rst = 1'b0;
    req = 2'b01; a0 = 4'd7; b0 = 4'd14;
    cycle();
    checks++;
    if (busy !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL reset_precalc: got busy=%b gnt=%b, expected busy=1 gnt=01", busy, gnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, busy, product} !== '0) begin
      errors++;
      $display("FAIL reset_async: got gnt=%b done=%b busy=%b product=%h, expected all 0", gnt, done, busy, product);
    end
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done[%0d]: got done=%b busy=%b, expected done=00 busy=0", i, done, busy);
      end
    end
  endtask

  task automatic test_single();
    req = 2'b01; a0 = 4'd7; b0 = 4'd14;
    cycle();
    checks++;
    if (gnt !== 2'b01 || done !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b done=%b busy=%b, expected 01 00 1", gnt, done, busy);
    end
    cycle();
    checks++;
    if (done !== 2'b01 || product !== 8'h62) begin
      errors++;
      $display("FAIL single_done: got done=%b product=%h, expected done=01 product=62", done, product);
    end
    req = 2'b00;
    cycle();
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || product !== 8'h62) begin
      errors++;
      $display("FAIL single_idle: got gnt=%b done=%b busy=%b product=%h, expected 00 00 0 62", gnt, done, busy, product);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req = 2'b11; a0 = 4'd2; b0 = 4'd10; a1 = 4'd5; b1 = 4'd7;
    cycle();
    cycle();
    checks++;
    if (done !== 2'b01 || product !== 8'd20) begin
      errors++;
      $display("FAIL contention_first: got done=%b product=%0d, expected done=01 product=20", done, product);
    end
    req = 2'b10;
    cycle();
    cycle();
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL contention_grant1: got gnt=%b, expected 10", gnt);
    end
    cycle();
    checks++;
    if (done !== 2'b10 || product !== 8'd35) begin
      errors++;
      $display("FAIL contention_second: got done=%b product=%0d, expected done=10 product=35", done, product);
    end
    req = 2'b00;
    cycle();
  endtask

  task automatic test_fairness();
    int n0, n1;
    logic [1:0] want;
    n0 = 0; n1 = 0;
    want = 2'b01;   // port 1 was served last, so port 0 goes first
    req = 2'b11; a0 = 4'd3; b0 = 4'd4; a1 = 4'd6; b1 = 4'd9;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (done == 2'b01) n0++;
      if (done == 2'b10) n1++;
      if (i % 3 == 2) begin
        checks++;
        if (done !== want) begin
          errors++;
          $display("FAIL fairness_seq[%0d]: got done=%b, expected %b", i, done, want);
        end
        want = ~want;
      end else begin
        checks++;
        if (done !== 2'b00) begin
          errors++;
          $display("FAIL fairness_gap[%0d]: got done=%b, expected 00", i, done);
        end
      end
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL fairness_count: got port0=%0d port1=%0d, expected 2 and 2", n0, n1);
    end
    req = 2'b00;
    cycle();
  endtask

  task automatic test_operand_stability();
    logic [W-1:0] ta [2] = '{4'd1, 4'd4};
    logic [W-1:0] tb [2] = '{4'd1, 4'd7};
    logic [7:0]   tp [2] = '{8'd1, 8'd28};
    req = 2'b01; a0 = 4'd5; b0 = 4'd5;
    cycle();
    a0 = 4'd1;
    cycle();
    checks++;
    if (done !== 2'b01 || product !== 8'd25) begin
      errors++;
      $display("FAIL stable_capture: got done=%b product=%0d, expected done=01 product=25", done, product);
    end
    req = 2'b00;
    cycle();
    for (int i = 0; i < 2; i++) begin
      req = 2'b01; a0 = ta[i]; b0 = tb[i];
      cycle();
      cycle();
      checks++;
      if (done !== 2'b01 || product !== tp[i]) begin
        errors++;
        $display("FAIL stable_op[%0d]: got done=%b product=%0d, expected done=01 product=%0d", i, done, product, tp[i]);
      end
      req = 2'b00;
      cycle();
    end
  endtask

  task automatic test_boundary();
    req = 2'b10; a1 = 4'd15; b1 = 4'd15;
    cycle();
    cycle();
    checks++;
    if (done !== 2'b10 || product !== 8'hE1) begin
      errors++;
      $display("FAIL boundary_max: got done=%b product=%h, expected done=10 product=e1", done, product);
    end
    req = 2'b00;
    cycle();
    req = 2'b01; a0 = 4'd0; b0 = 4'd13;
    cycle();
    cycle();
    checks++;
    if (done !== 2'b01 || product !== 8'd0) begin
      errors++;
      $display("FAIL boundary_zero: got done=%b product=%h, expected done=01 product=00", done, product);
    end
    req = 2'b00;
    cycle();
    req = 2'b01; a0 = 4'd3; b0 = 4'd3;
    cycle();
    req = 2'b00;
    cycle();
    checks++;
    if (done !== 2'b01 || product !== 8'd9) begin
      errors++;
      $display("FAIL boundary_early_drop: got done=%b product=%0d, expected done=01 product=9", done, product);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = 2'($urandom_range(0, 3));
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      cycle();
      checks++;
      if (gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b, expected %b", i, gnt, exp_gnt());
      end
      checks++;
      if (done !== exp_done()) begin
        errors++;
        $display("FAIL rand_done[%0d]: got %b, expected %b", i, done, exp_done());
      end
      checks++;
      if (busy !== exp_busy()) begin
        errors++;
        $display("FAIL rand_busy[%0d]: got %b, expected %b", i, busy, exp_busy());
      end
      checks++;
      if (product !== exp_prod()) begin
        errors++;
        $display("FAIL rand_product[%0d]: got %h, expected %h", i, product, exp_prod());
      end
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_operand_stability();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
